hoops_spawn_scheduler: RTL and testbench
========================================

Name: hoops_spawn_scheduler

Overview:
Central scheduler for the pool of falling hoops. It tracks which of NUM_HOOPS hoop slots are in flight and decides once per frame whether a new hoop spawns. It picks the lowest free slot, generates a pseudo-random spawn X, and issues a one-cycle spawn request to that slot's movement block. It also counts catches and optionally shortens the spawn interval as the game progresses.

Parameters:
NUM_HOOPS, 4, number of hoop slots/mover instances (2..8)
BASE_INTERVAL, 90, frames between spawns at level 0 (1..255)
MIN_INTERVAL, 30, lower bound of the spawn interval, in frames
INTERVAL_STEP, 10, frames removed from the interval per level
LEVEL_UP_CATCHES, 5, catches needed per level increment
X_MIN, 0, smallest spawn X
X_MAX, 611, largest spawn X (screen width 640 minus hoop width 28, minus 1); X_MAX-X_MIN+1 must be ≥512 and ≤1024

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
startGame  in  1  one-cycle pulse; (re)starts scheduling
pause  in  1  level; freezes scheduling
hoopDone  in  NUM_HOOPS  per-slot pulse: hoop left the screen bottom
hoopCaught  in  NUM_HOOPS  per-slot pulse: player passed through the hoop
spawnReq  out  NUM_HOOPS  one-hot, one-cycle spawn strobe
spawnX  out  11  spawn X; valid from the spawnReq cycle until the next spawn
slotActive  out  NUM_HOOPS  1 = slot in flight
catchCount  out  8  total catches, saturates at 255
level  out  4  current difficulty level, saturating

Behaviour:
- Reset (async): FSM=IDLE; spawnReq=0, spawnX=0, slotActive=0, catchCount=0, level=0, frameCnt=0, LFSR=16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock while out of reset.
- X derivation: c=lfsr[9:0], R=X_MAX-X_MIN+1. If c≥R then c−R, else c. Add X_MIN. The result is always in [X_MIN,X_MAX].
- curInterval = max(MIN_INTERVAL, BASE_INTERVAL − level*INTERVAL_STEP). Compute it without negative wrap.
- FSM states: IDLE, RUN, SELECT, ISSUE.
  - IDLE: wait for startGame.
  - Any state with startGame=1: clear slotActive, catchCount and level; set frameCnt=0; go to RUN. This takes priority over every other event.
  - RUN: on startOfFrame with pause=0, go to SELECT if frameCnt==0, otherwise decrement frameCnt. With pause=1, frameCnt is frozen.
  - SELECT (1 cycle): if pause=1 or no free slot, return to RUN with frameCnt left at 0, so the spawn is retried on the next frame. Otherwise latch idx = lowest free slot and spawnX from the LFSR, then go to ISSUE.
  - ISSUE (1 cycle): spawnReq[idx]=1, slotActive[idx] set, frameCnt=curInterval−1, go to RUN.
- Timing: first spawn follows the first startOfFrame after startGame. spawnReq asserts 2 cycles after that startOfFrame. Steady-state spacing is exactly curInterval frames.
- Slot release: hoopDone[i] or hoopCaught[i] clears slotActive[i] in the same clock. Pulses on inactive slots are ignored entirely, including for counting.
- Done and caught on the same slot in the same cycle count as one catch.
- Multiple catches in one cycle all count: catchCount adds popcount, saturating.
- Release and ISSUE targeting the same slot in the same cycle: set wins; the slot was free at SELECT.
- Level: a catch counter counts 0..LEVEL_UP_CATCHES−1. On wrap, level increments (saturating at 15). Incrementing stops once curInterval==MIN_INTERVAL.
- spawnReq is never issued in IDLE or while pause=1.

Optional Feature:
HOOP_DIFFICULTY_RAMP_EN
- Defined: level advances as described, and curInterval shrinks with level.
- Undefined: level is held at 0, and curInterval=BASE_INTERVAL always. catchCount still counts.

Test Plan:
1. Reset, then startGame, then startOfFrame → spawnReq=4'b0001 exactly 2 cycles later, single-cycle. slotActive=0001. spawnX within 0..611.
2. No releases, BASE_INTERVAL=90 → spawns at frames 0, 90, 180, 270 to slots 0,1,2,3. At frame 360 there is no spawn; the scheduler retries every frame. hoopDone[2] at frame 400 → the next frame spawns slot 2.
3. pause=1 for 20 frames mid-interval → spawn delayed by exactly 20 frames. No spawnReq while paused, even if frameCnt==0.
4. hoopCaught[1] and hoopDone[1] in the same cycle → catchCount+1. hoopCaught[3] on an inactive slot → no change.
5. RAMP_EN defined, 5 catches → level=1, next spacing 80 frames. After 30 catches, level stays 6 and spacing stays 30. Undefined: spacing stays 90.
6. resetN low mid-ISSUE → all outputs 0 immediately. startGame during RUN with 3 active slots → slotActive=0, catchCount=0, spawn on the next frame.

Source files
------------

// File: rtl/hoops_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hoops_spawn_scheduler
//  Description : Central scheduler for the pool of falling hoops. It tracks
//                which hoop slots are in flight and decides once per frame
//                whether a new hoop spawns. A spawn takes the lowest free
//                slot, gets a pseudo-random X position and drives a one-cycle
//                one-hot strobe to that slot's mover. It also counts catches
//                and, when enabled, shortens the spawn interval as the level
//                rises.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: HOOP_DIFFICULTY_RAMP_EN
//    defined   : level advances every LEVEL_UP_CATCHES catches and the spawn
//                interval shrinks by INTERVAL_STEP per level (floor at
//                MIN_INTERVAL).
//    undefined : level stays 0 and the interval is always BASE_INTERVAL.
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock
//    resetN       in   asynchronous active-low reset
//    startOfFrame in   one-cycle pulse per video frame
//    startGame    in   one-cycle pulse, (re)starts scheduling
//    pause        in   level, freezes scheduling
//    hoopDone     in   [NUM_HOOPS] per-slot pulse, hoop left the screen
//    hoopCaught   in   [NUM_HOOPS] per-slot pulse, player caught the hoop
//    spawnReq     out  [NUM_HOOPS] one-hot, one-cycle spawn strobe
//    spawnX       out  [11] spawn X, valid from spawnReq until next spawn
//    slotActive   out  [NUM_HOOPS] 1 = slot in flight
//    catchCount   out  [8] total catches, saturating at 255
//    level        out  [4] difficulty level, saturating
// ============================================================================
module hoops_spawn_scheduler #(
  parameter int NUM_HOOPS        = 4,
  parameter int BASE_INTERVAL    = 90,
  parameter int MIN_INTERVAL     = 30,
  parameter int INTERVAL_STEP    = 10,
  parameter int LEVEL_UP_CATCHES = 5,
  parameter int X_MIN            = 0,
  parameter int X_MAX            = 611
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 startGame,
  input  logic                 pause,
  input  logic [NUM_HOOPS-1:0] hoopDone,
  input  logic [NUM_HOOPS-1:0] hoopCaught,
  output logic [NUM_HOOPS-1:0] spawnReq,
  output logic [10:0]          spawnX,
  output logic [NUM_HOOPS-1:0] slotActive,
  output logic [7:0]           catchCount,
  output logic [3:0]           level
);

`ifdef HOOP_DIFFICULTY_RAMP_EN
  localparam bit C_RAMP_EN = 1'b1;
`else
  localparam bit C_RAMP_EN = 1'b0;
`endif

  localparam int C_IDX_W   = $clog2(NUM_HOOPS);
  localparam int C_X_RANGE = X_MAX - X_MIN + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SELECT = 2'd2,
    ST_ISSUE  = 2'd3
  } state_t;

  // Spawn interval for a given level, clamped at MIN_INTERVAL. The
  // subtraction is only done when it cannot go negative.
  function automatic logic [7:0] interval_for(input logic [3:0] lvl);
    int dec;
    dec = int'(lvl) * INTERVAL_STEP;
    if (dec >= BASE_INTERVAL) begin
      return 8'(MIN_INTERVAL);
    end else if ((BASE_INTERVAL - dec) < MIN_INTERVAL) begin
      return 8'(MIN_INTERVAL);
    end else begin
      return 8'(BASE_INTERVAL - dec);
    end
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q,      state_d;
  logic [15:0]          lfsr_q,       lfsr_d;
  logic [7:0]           frame_cnt_q,  frame_cnt_d;
  logic [C_IDX_W-1:0]   idx_q,        idx_d;
  logic [10:0]          spawn_x_q,    spawn_x_d;
  logic [NUM_HOOPS-1:0] slot_q,       slot_d;
  logic [7:0]           catch_cnt_q,  catch_cnt_d;
  logic [3:0]           level_q,      level_d;
  logic [7:0]           sub_cnt_q,    sub_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [NUM_HOOPS-1:0] w_caught;
  logic [NUM_HOOPS-1:0] w_release;
  logic [3:0]           w_pop;
  logic                 w_free_found;
  logic [C_IDX_W-1:0]   w_free_idx;
  logic [10:0]          w_x_raw;
  logic [10:0]          w_x_sel;
  logic [7:0]           w_cur_interval;
  logic [8:0]           w_catch_sum;
  logic [3:0]           w_lvl_next;
  logic [7:0]           w_sub_next;
  logic                 w_spawn_fire;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // One conditional subtract folds 0..1023 into the X range; this is exact
  // because the range is at least 512 wide.
  assign w_x_raw = {1'b0, lfsr_q[9:0]};
  assign w_x_sel = ((w_x_raw >= 11'(C_X_RANGE)) ? (w_x_raw - 11'(C_X_RANGE)) : w_x_raw)
                   + 11'(X_MIN);

  assign w_cur_interval = C_RAMP_EN ? interval_for(level_q) : 8'(BASE_INTERVAL);

  // Pulses on slots that are not in flight are ignored entirely. A slot with
  // both done and caught counts once, via the caught bit.
  assign w_caught  = hoopCaught & slot_q;
  assign w_release = (hoopDone | hoopCaught) & slot_q;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < NUM_HOOPS; i++) begin
      w_pop = w_pop + 4'(w_caught[i]);
    end
  end

  assign w_catch_sum = {1'b0, catch_cnt_q} + 9'(w_pop);

  // Lowest free slot: scan from the top so the lowest index wins.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_HOOPS - 1; i >= 0; i--) begin
      if (!slot_q[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = C_IDX_W'(i);
      end
    end
  end

  // Level progression, one catch at a time so several catches in one cycle
  // can cross a level boundary correctly. Levels stop rising once the
  // interval has reached its floor.
  always_comb begin
    w_lvl_next = level_q;
    w_sub_next = sub_cnt_q;
    for (int i = 0; i < NUM_HOOPS; i++) begin
      if (w_caught[i]) begin
        if (w_sub_next >= 8'(LEVEL_UP_CATCHES - 1)) begin
          w_sub_next = 8'd0;
          if ((w_lvl_next != 4'hF) &&
              (interval_for(w_lvl_next) != 8'(MIN_INTERVAL))) begin
            w_lvl_next = w_lvl_next + 4'd1;
          end
        end else begin
          w_sub_next = w_sub_next + 8'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    idx_d        = idx_q;
    spawn_x_d    = spawn_x_q;
    slot_d       = slot_q & ~w_release;
    catch_cnt_d  = w_catch_sum[8] ? 8'hFF : w_catch_sum[7:0];
    level_d      = C_RAMP_EN ? w_lvl_next : 4'd0;
    sub_cnt_d    = w_sub_next;
    w_spawn_fire = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end

      ST_RUN: begin
        if (startOfFrame && !pause) begin
          if (frame_cnt_q == 8'd0) begin
            state_d = ST_SELECT;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end

      ST_SELECT: begin
        // frame_cnt stays 0 on a failed attempt, so the next frame retries.
        if (pause || !w_free_found) begin
          state_d = ST_RUN;
        end else begin
          idx_d     = w_free_idx;
          spawn_x_d = w_x_sel;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // A pause arriving between select and issue defers the spawn to the
        // next frame instead of strobing while paused.
        if (pause) begin
          state_d = ST_RUN;
        end else begin
          w_spawn_fire  = 1'b1;
          slot_d[idx_q] = 1'b1;  // set wins over a same-cycle release
          frame_cnt_d   = w_cur_interval - 8'd1;
          state_d       = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Game (re)start overrides every other event.
    if (startGame) begin
      state_d      = ST_RUN;
      frame_cnt_d  = 8'd0;
      slot_d       = '0;
      catch_cnt_d  = 8'd0;
      level_d      = 4'd0;
      sub_cnt_d    = 8'd0;
      w_spawn_fire = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= 16'hACE1;
      frame_cnt_q <= 8'd0;
      idx_q       <= '0;
      spawn_x_q   <= 11'd0;
      slot_q      <= '0;
      catch_cnt_q <= 8'd0;
      level_q     <= 4'd0;
      sub_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      idx_q       <= idx_d;
      spawn_x_q   <= spawn_x_d;
      slot_q      <= slot_d;
      catch_cnt_q <= catch_cnt_d;
      level_q     <= level_d;
      sub_cnt_q   <= sub_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign spawnReq   = w_spawn_fire ? (NUM_HOOPS'(1) << idx_q) : '0;
  assign spawnX     = spawn_x_q;
  assign slotActive = slot_q;
  assign catchCount = catch_cnt_q;
  assign level      = level_q;

endmodule
`default_nettype wire

// File: tb/tb_hoops_spawn_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hoops_spawn_scheduler
//  Description : Directed self-checking bench for hoops_spawn_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hoops_spawn_scheduler;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       startGame = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] hoopDone = 4'd0;
  logic [3:0] hoopCaught = 4'd0;
  logic [3:0] spawnReq;
  logic [10:0] spawnX;
  logic [3:0] slotActive;
  logic [7:0] catchCount;
  logic [3:0] level;

  int n_tests = 0;
  int n_fail  = 0;

  int frame_no = 0;
  int sp_cnt = 0;
  int sp_frame = -1;
  logic [3:0] sp_req = 4'd0;
  int x_err = 0;
  int pause_spawn = 0;

`ifdef HOOP_DIFFICULTY_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  hoops_spawn_scheduler #(
    .NUM_HOOPS(4), .BASE_INTERVAL(90), .MIN_INTERVAL(30), .INTERVAL_STEP(10),
    .LEVEL_UP_CATCHES(5), .X_MIN(0), .X_MAX(611)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .startGame(startGame), .pause(pause), .hoopDone(hoopDone),
    .hoopCaught(hoopCaught), .spawnReq(spawnReq), .spawnX(spawnX),
    .slotActive(slotActive), .catchCount(catchCount), .level(level)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value from one clock earlier, which is
  // what the scheduler samples in its select cycle.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_lfsr <= 16'hACE1;
      m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  function automatic logic [10:0] x_of(input logic [15:0] v);
    logic [10:0] c;
    c = {1'b0, v[9:0]};
    if (c >= 11'd612) c = c - 11'd612;
    return c;
  endfunction

  always @(negedge clk) begin
    if (spawnReq != 4'd0) begin
      sp_cnt   = sp_cnt + 1;
      sp_frame = frame_no;
      sp_req   = spawnReq;
      if (pause) pause_spawn = pause_spawn + 1;
      if (spawnX !== x_of(m_prev)) x_err = x_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_no = frame_no + 1;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic run_to(input int n);
    while (frame_no < n) frame();
  endtask

  task automatic wait_spawn();
    int s0;
    s0 = sp_cnt;
    for (int k = 0; k < 200 && sp_cnt == s0; k++) frame();
  endtask

  task automatic pulse(input logic [3:0] d, input logic [3:0] c);
    hoopDone = d;
    hoopCaught = c;
    step();
    hoopDone = 4'd0;
    hoopCaught = 4'd0;
  endtask

  initial begin
    int f1, f2, exp_next;
    bit got_issue;

    // ---- reset state
    repeat (3) step();
    check("rst_spawnReq", 32'(spawnReq), 0);
    check("rst_spawnX", 32'(spawnX), 0);
    check("rst_slotActive", 32'(slotActive), 0);
    check("rst_catchCount", 32'(catchCount), 0);
    check("rst_level", 32'(level), 0);
    resetN = 1'b1;
    step();

    // ---- first spawn: 2 cycles after the first frame pulse
    startGame = 1'b1; step(); startGame = 1'b0; step();
    frame_no = 0;
    startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
    check("t1_req_early", 32'(spawnReq), 0);
    step();
    check("t1_req", 32'(spawnReq), 1);
    check("t1_x_exact", 32'(spawnX), 32'(x_of(m_prev)));
    check("t1_x_range", 32'(spawnX <= 11'd611), 1);
    step();
    check("t1_req_single", 32'(spawnReq), 0);
    check("t1_active", 32'(slotActive), 1);
    step();

    // ---- steady spawning, full pool, retry
    run_to(89);
    check("t2_no_early", 32'(sp_cnt), 1);
    run_to(90);
    check("t2_f90_frame", 32'(sp_frame), 90);
    check("t2_f90_slot", 32'(sp_req), 2);
    run_to(270);
    check("t2_f270_slot", 32'(sp_req), 8);
    check("t2_cnt4", 32'(sp_cnt), 4);
    check("t2_full", 32'(slotActive), 15);
    run_to(399);
    check("t2_no_spawn_full", 32'(sp_cnt), 4);
    pulse(4'b0100, 4'b0000);
    check("t2_release2", 32'(slotActive), 32'(4'b1011));
    frame();
    check("t2_retry_frame", 32'(sp_frame), 400);
    check("t2_retry_slot", 32'(sp_req), 4);

    // ---- pause delays the spawn by the paused frames
    pulse(4'b0001, 4'b0000);
    run_to(450);
    pause = 1'b1;
    run_to(470);
    pause = 1'b0;
    run_to(509);
    check("t3_no_spawn_509", 32'(sp_cnt), 5);
    run_to(510);
    check("t3_spawn_frame", 32'(sp_frame), 510);
    check("t3_spawn_slot", 32'(sp_req), 1);

    // ---- catch counting
    pulse(4'b0010, 4'b0010);
    check("t4_done_caught", 32'(catchCount), 1);
    check("t4_release1", 32'(slotActive), 32'(4'b1101));
    pulse(4'b0000, 4'b0010);
    check("t4_inactive_ignored", 32'(catchCount), 1);
    pulse(4'b0000, 4'b1101);
    check("t4_multi", 32'(catchCount), 4);
    check("t4_all_free", 32'(slotActive), 0);
    run_to(600);
    check("t5_f600_slot", 32'(sp_req), 1);
    pulse(4'b0000, 4'b0001);
    check("t5_catch5", 32'(catchCount), 5);
    check("t5_level", 32'(level), RAMP ? 1 : 0);

    // ---- spacing after the level change
    run_to(690);
    check("t5_f690", 32'(sp_frame), 690);
    exp_next = RAMP ? 770 : 780;
    run_to(exp_next - 1);
    check("t5_no_early", 32'(sp_frame), 690);
    run_to(exp_next);
    check("t5_next_spacing", 32'(sp_frame), 32'(exp_next));

    // ---- catch up to 35 and check saturation of level / spacing
    for (int k = 0; k < 3000 && catchCount < 8'd35; k++) begin
      frame();
      if (slotActive != 4'd0) pulse(4'b0000, slotActive);
    end
    check("t5_catch35", 32'(catchCount), 35);
    check("t5_level_sat", 32'(level), RAMP ? 6 : 0);
    wait_spawn();
    f1 = sp_frame;
    wait_spawn();
    f2 = sp_frame;
    check("t5_min_spacing", 32'(f2 - f1), RAMP ? 30 : 90);
    wait_spawn();
    check("t6_three_active", 32'(slotActive), 32'(4'b0111));

    // ---- restart during RUN
    startGame = 1'b1; step(); startGame = 1'b0;
    check("t6_restart_slots", 32'(slotActive), 0);
    check("t6_restart_catch", 32'(catchCount), 0);
    check("t6_restart_level", 32'(level), 0);
    frame();
    check("t6_restart_spawn_frame", 32'(sp_frame), 32'(frame_no));
    check("t6_restart_spawn_slot", 32'(sp_req), 1);
    pulse(4'b0000, 4'b0001);
    check("t6_catch_after_restart", 32'(catchCount), 1);

    // ---- asynchronous reset in the middle of an issue cycle
    got_issue = 1'b0;
    for (int k = 0; k < 200 && !got_issue; k++) begin
      frame_no = frame_no + 1;
      startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step();
      if (spawnReq != 4'd0) got_issue = 1'b1;
      else begin step(); step(); end
    end
    check("t6_issue_seen", 32'(spawnReq), 1);
    #1 resetN = 1'b0;
    #1;
    check("t6_rst_spawnReq", 32'(spawnReq), 0);
    check("t6_rst_slotActive", 32'(slotActive), 0);
    check("t6_rst_spawnX", 32'(spawnX), 0);
    check("t6_rst_catchCount", 32'(catchCount), 0);
    check("t6_rst_level", 32'(level), 0);

    check("spawn_x_model", 32'(x_err), 0);
    check("no_spawn_while_paused", 32'(pause_spawn), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
